// File: rtl/cache_fill_fsm_if.sv
// ============================================================================
// Module      : cache_fill_fsm_if
// Description : Miss-request, memory-read and cache-write signals of the
//               cache block-fill controller, bundled with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cache_fill_fsm_if #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
);
    localparam int c_OFF_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;

    logic                  miss_detected;
    logic [ADDR_WIDTH-1:0] miss_address;
    logic [15:0]           memory_data;
    logic                  memory_data_valid;
    logic [ADDR_WIDTH-1:0] memory_address;
    logic                  mem_enable;
    logic                  fsm_busy;
    logic                  write_data_array;
    logic [c_OFF_W-1:0]    cache_word_offset;
    logic [15:0]           cache_write_data;
    logic                  write_tag_array;
    logic                  fill_error;

    // The fill controller is the master; cache/memory environment is the slave.
    modport master (
        input  miss_detected, miss_address, memory_data, memory_data_valid,
        output memory_address, mem_enable, fsm_busy, write_data_array,
               cache_word_offset, cache_write_data, write_tag_array, fill_error
    );

    modport slave (
        output miss_detected, miss_address, memory_data, memory_data_valid,
        input  memory_address, mem_enable, fsm_busy, write_data_array,
               cache_word_offset, cache_write_data, write_tag_array, fill_error
    );
endinterface

`default_nettype wire

// File: rtl/cache_fill_fsm.sv
// ============================================================================
// Module      : cache_fill_fsm
// Description : Cache block-fill controller. Issues one word read per cycle
//               and writes returned words into the data array by counting
//               memory_data_valid pulses. Optional watchdog abort enabled by
//               macro CACHE_FILL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    cache_fill_fsm_if.master  bus
);

    localparam int c_OFF_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int c_CNT_W = c_OFF_W + 1;
    localparam int c_LSB_W = c_OFF_W + 1;

    localparam logic [c_CNT_W-1:0]    c_WORDS     = c_CNT_W'(WORDS_PER_BLOCK);
    localparam logic [c_CNT_W-1:0]    c_WORDS_M1  = c_CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [c_OFF_W-1:0]    c_LAST_OFF  = c_OFF_W'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_WIDTH-1:0] c_BASE_MASK = {ADDR_WIDTH{1'b1}} << c_LSB_W;
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_STEP = ADDR_WIDTH'(2);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr,  w_addr_next;
    logic [c_CNT_W-1:0]    r_issue, w_issue_next;
    logic [c_OFF_W-1:0]    r_recv,  w_recv_next;
    logic                  w_issuing;
    logic                  w_write;
    logic                  w_last;
    logic                  w_abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_issue <= '0;
            r_recv  <= '0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
            r_issue <= w_issue_next;
            r_recv  <= w_recv_next;
        end
    end

    // r_addr is the live request address: it stops advancing on the last
    // request so it holds that address once issuing is complete.
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_issue_next = r_issue;
        w_recv_next  = r_recv;
        w_issuing    = 1'b0;
        w_write      = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.miss_detected) begin
                    w_state_next = S_FILL;
                    w_addr_next  = bus.miss_address & c_BASE_MASK;
                    w_issue_next = '0;
                    w_recv_next  = '0;
                end
            end
            S_FILL: begin
                w_issuing = (r_issue < c_WORDS);
                if (w_issuing) begin
                    w_issue_next = r_issue + c_CNT_W'(1);
                    if (r_issue < c_WORDS_M1) begin
                        w_addr_next = r_addr + c_ADDR_STEP;
                    end
                end
                w_write = bus.memory_data_valid;
                w_last  = bus.memory_data_valid && (r_recv == c_LAST_OFF);
                if (bus.memory_data_valid) begin
                    w_recv_next = r_recv + c_OFF_W'(1);
                end
                if (w_last || w_abort) begin
                    w_state_next = S_IDLE;
                    w_recv_next  = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifdef CACHE_FILL_TIMEOUT_EN
    logic [4:0] r_wdog;
    logic [4:0] w_wdog_next;

    // Counts consecutive FILL cycles without a valid; abort fires in the
    // cycle the count reaches 31.
    always_comb begin
        w_wdog_next = bus.memory_data_valid ? 5'd0 : (r_wdog + 5'd1);
    end

    assign w_abort = (r_state == S_FILL) && (w_wdog_next == 5'd31);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog <= '0;
        end else if (r_state == S_IDLE) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= w_wdog_next;
        end
    end

    assign bus.fill_error = w_abort;
`else
    assign w_abort        = 1'b0;
    assign bus.fill_error = 1'b0;
`endif

    assign bus.mem_enable        = w_issuing;
    assign bus.memory_address    = r_addr;
    assign bus.fsm_busy          = (r_state == S_FILL);
    assign bus.write_data_array  = w_write;
    assign bus.cache_word_offset = r_recv;
    assign bus.cache_write_data  = bus.memory_data;
    assign bus.write_tag_array   = w_last;

endmodule

`default_nettype wire
